// File: rtl/fd_stage_reg.sv
// Fetch->decode pipeline register with stall (hold) and bubble (NOP inject) control.
// Latency: 1 cycle, registered outputs only, no input-to-output combinational path.
// Backpressure: d_stall holds the slot indefinitely; stall+bubble together holds and sets sticky ctl_err.
//
// Ports: clk/rst (sync active-high), f_* fetch fields + f_valid in, d_stall/d_bubble control in,
//        d_* registered fields + d_valid out, ctl_err sticky illegal-control flag,
//        stall_cnt/bubble_cnt saturating event counters.
// Build option: define FD_PERF_CNT_EN to build the counters; otherwise both counter outputs are tied to 0.
module fd_stage_reg #(
    parameter int                N         = 64,
    parameter int                STAT_W    = 2,
    parameter logic [3:0]        NOP_ICODE = 4'h1,
    parameter logic [3:0]        REG_NONE  = 4'hF,
    parameter logic [STAT_W-1:0] STAT_AOK  = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [3:0]        f_rA,
    input  logic [3:0]        f_rB,
    input  logic [N-1:0]      f_valC,
    input  logic [N-1:0]      f_valP,
    input  logic [STAT_W-1:0] f_stat,
    input  logic              f_valid,
    input  logic              d_stall,
    input  logic              d_bubble,
    output logic [3:0]        d_icode,
    output logic [3:0]        d_ifun,
    output logic [3:0]        d_rA,
    output logic [3:0]        d_rB,
    output logic [N-1:0]      d_valC,
    output logic [N-1:0]      d_valP,
    output logic [STAT_W-1:0] d_stat,
    output logic              d_valid,
    output logic              ctl_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        ra;
        logic [3:0]        rb;
        logic [N-1:0]      valc;
        logic [N-1:0]      valp;
        logic [STAT_W-1:0] stat;
        logic              valid;
    } slot_t;

    // Contents of an empty slot: used both for reset and for bubble injection.
    localparam slot_t BUBBLE_SLOT = '{
        icode: NOP_ICODE,
        ifun:  4'h0,
        ra:    REG_NONE,
        rb:    REG_NONE,
        valc:  '0,
        valp:  '0,
        stat:  STAT_AOK,
        valid: 1'b0
    };

    slot_t slot_q, slot_d;
    logic  ctl_err_q, ctl_err_d;

    always_comb begin
        slot_d    = slot_q;
        ctl_err_d = ctl_err_q;
        if (d_stall) begin
            // Stall beats bubble; asking for both is a hazard-unit bug worth remembering.
            ctl_err_d = ctl_err_q | d_bubble;
        end else if (d_bubble) begin
            slot_d = BUBBLE_SLOT;
        end else begin
            slot_d = '{
                icode: f_icode,
                ifun:  f_ifun,
                ra:    f_rA,
                rb:    f_rB,
                valc:  f_valC,
                valp:  f_valP,
                stat:  f_stat,
                valid: f_valid
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= BUBBLE_SLOT;
            ctl_err_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            ctl_err_q <= ctl_err_d;
        end
    end

    assign d_icode = slot_q.icode;
    assign d_ifun  = slot_q.ifun;
    assign d_rA    = slot_q.ra;
    assign d_rB    = slot_q.rb;
    assign d_valC  = slot_q.valc;
    assign d_valP  = slot_q.valp;
    assign d_stat  = slot_q.stat;
    assign d_valid = slot_q.valid;
    assign ctl_err = ctl_err_q;

`ifdef FD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (d_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (d_bubble && !d_stall && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fd_stage_reg.sv
module tb_fd_stage_reg;

    localparam int N      = 64;
    localparam int STAT_W = 2;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [3:0]        f_icode, f_ifun, f_rA, f_rB;
    logic [N-1:0]      f_valC, f_valP;
    logic [STAT_W-1:0] f_stat;
    logic              f_valid, d_stall, d_bubble;
    logic [3:0]        d_icode, d_ifun, d_rA, d_rB;
    logic [N-1:0]      d_valC, d_valP;
    logic [STAT_W-1:0] d_stat;
    logic              d_valid, ctl_err;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    fd_stage_reg #(.N(N), .STAT_W(STAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat), .f_valid(f_valid),
        .d_stall(d_stall), .d_bubble(d_bubble),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
        .d_valC(d_valC), .d_valP(d_valP), .d_stat(d_stat), .d_valid(d_valid),
        .ctl_err(ctl_err), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    // Reference model: the instruction record the decode slot should hold.
    logic [3:0]        m_icode, m_ifun, m_rA, m_rB;
    logic [N-1:0]      m_valC, m_valP;
    logic [STAT_W-1:0] m_stat;
    logic              m_valid, m_err;
    int                m_scnt, m_bcnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_bubble();
        m_icode = 4'h1; m_ifun = 4'h0; m_rA = 4'hF; m_rB = 4'hF;
        m_valC = '0; m_valP = '0; m_stat = '0; m_valid = 1'b0;
    endtask

    task automatic check_all();
        chk("d_icode", 64'(d_icode), 64'(m_icode));
        chk("d_ifun",  64'(d_ifun),  64'(m_ifun));
        chk("d_rA",    64'(d_rA),    64'(m_rA));
        chk("d_rB",    64'(d_rB),    64'(m_rB));
        chk("d_valC",  d_valC,       m_valC);
        chk("d_valP",  d_valP,       m_valP);
        chk("d_stat",  64'(d_stat),  64'(m_stat));
        chk("d_valid", 64'(d_valid), 64'(m_valid));
        chk("ctl_err", 64'(ctl_err), 64'(m_err));
`ifdef FD_PERF_CNT_EN
        chk("stall_cnt",  64'(stall_cnt),  64'(m_scnt));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bcnt));
`else
        chk("stall_cnt_tied",  64'(stall_cnt),  64'd0);
        chk("bubble_cnt_tied", 64'(bubble_cnt), 64'd0);
`endif
    endtask

    task automatic set_f(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                         input logic [1:0] st, input logic vl);
        f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb;
        f_valC = vc; f_valP = vp; f_stat = st; f_valid = vl;
    endtask

    task automatic rand_f();
        set_f(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom), 1'($urandom));
    endtask

    // Apply one clock edge with the given controls, advance the model, then check all outputs.
    task automatic step(input logic r, input logic s, input logic b);
        rst = r; d_stall = s; d_bubble = b;
        @(posedge clk);
        if (r) begin
            model_bubble();
            m_err = 1'b0; m_scnt = 0; m_bcnt = 0;
        end else if (s) begin
            if (b) m_err = 1'b1;
            if (m_scnt < CNT_MAX) m_scnt++;
        end else if (b) begin
            model_bubble();
            if (m_bcnt < CNT_MAX) m_bcnt++;
        end else begin
            m_icode = f_icode; m_ifun = f_ifun; m_rA = f_rA; m_rB = f_rB;
            m_valC = f_valC; m_valP = f_valP; m_stat = f_stat; m_valid = f_valid;
        end
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; d_stall = 1'b0; d_bubble = 1'b0;
        rand_f();

        // Reset state
        step(1'b1, 1'b0, 1'b0);
        chk("t1_icode", 64'(d_icode), 64'h1);
        chk("t1_rA",    64'(d_rA),    64'hF);
        chk("t1_rB",    64'(d_rB),    64'hF);
        chk("t1_valid", 64'(d_valid), 64'h0);
        chk("t1_err",   64'(ctl_err), 64'h0);

        // Plain load
        set_f(4'h3, 4'h0, 4'hF, 4'h2, 64'h100, 64'h0A, 2'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_icode", 64'(d_icode), 64'h3);
        chk("t2_rB",    64'(d_rB),    64'h2);
        chk("t2_valC",  d_valC,       64'h100);
        chk("t2_valP",  d_valP,       64'h0A);
        chk("t2_valid", 64'(d_valid), 64'h1);

        // Multi-cycle stall holds the slot while fetch changes
        set_f(4'h6, 4'h5, 4'h1, 4'h2, 64'h1234, 64'h20, 2'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rand_f();
            step(1'b0, 1'b1, 1'b0);
            chk("t3_hold_ifun", 64'(d_ifun), 64'h5);
        end
        set_f(4'h2, 4'h0, 4'h3, 4'h4, 64'h0, 64'h22, 2'h1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_release_icode", 64'(d_icode), 64'h2);

        // Bubble then normal load
        set_f(4'h6, 4'h1, 4'h5, 4'h6, 64'h77, 64'h40, 2'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("t4_bub_icode", 64'(d_icode), 64'h1);
        chk("t4_bub_valid", 64'(d_valid), 64'h0);
        rand_f();
        step(1'b0, 1'b0, 1'b0);

        // Stall+bubble together: hold and set sticky error
        set_f(4'h5, 4'h0, 4'h1, 4'h7, 64'h8, 64'h50, 2'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        rand_f();
        step(1'b0, 1'b1, 1'b1);
        chk("t5_err_set",   64'(ctl_err), 64'h1);
        chk("t5_held_icode", 64'(d_icode), 64'h5);
        rand_f();
        step(1'b0, 1'b0, 1'b0);
        chk("t5_err_sticky", 64'(ctl_err), 64'h1);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_err_clear", 64'(ctl_err), 64'h0);

        // Counter saturation (counters only exist with the perf option)
        for (int i = 0; i < 20; i++) begin
            rand_f();
            step(1'b0, 1'b1, 1'b0);
        end
        rand_f();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
`ifdef FD_PERF_CNT_EN
        chk("t6_stall_sat", 64'(stall_cnt),  64'd15);
        chk("t6_bubble",    64'(bubble_cnt), 64'd2);
`endif
        step(1'b1, 1'b0, 1'b0);
        chk("t6_rst_scnt", 64'(stall_cnt),  64'd0);
        chk("t6_rst_bcnt", 64'(bubble_cnt), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_f();
            step(($urandom % 32) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
